// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - round counter and control sequencer for SHA-2 compression cores
module sha_round_sequencer #(
    parameter int ROUNDS    = 64,
    parameter int IDX_W     = 6,
    parameter int MSG_W     = 16,
    parameter int BLK_CNT_W = 8
) (
    input  logic                 inclk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 blk_valid,
    input  logic                 blk_last,
    output logic                 blk_ready,
    output logic                 init_h,
    output logic                 load,
    output logic                 round_en,
    output logic [IDX_W-1:0]     round_idx,
    output logic                 w_sel,
    output logic                 hash_upd,
    output logic [BLK_CNT_W-1:0] blk_cnt,
    output logic                 busy,
    output logic                 dig_valid,
    input  logic                 dig_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAITBLK,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t state;
    state_t state_nxt;
    logic   last_q;

    // State register; reset lands in IDLE so every decoded output drops at once
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode; abort overrides any transition
    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        init_h    = 1'b0;
        load      = 1'b0;
        round_en  = 1'b0;
        w_sel     = 1'b0;
        hash_upd  = 1'b0;
        dig_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                init_h    = 1'b1;
                state_nxt = S_WAITBLK;
            end
            S_WAITBLK: begin
                blk_ready = 1'b1;
                if (blk_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load      = 1'b1;
                state_nxt = S_ROUND;
            end
            S_ROUND: begin
                round_en = 1'b1;
                w_sel    = (int'(round_idx) < MSG_W);
                if (round_idx == LAST_IDX) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                hash_upd  = 1'b1;
                state_nxt = last_q ? S_DONE : S_WAITBLK;
            end
            S_DONE: begin
                dig_valid = 1'b1;
                if (dig_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Round index, block counter and last-block flag
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            round_idx <= '0;
            blk_cnt   <= '0;
            last_q    <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            round_idx <= '0;
            blk_cnt   <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    blk_cnt <= '0;
                end
                S_WAITBLK: begin
                    if (blk_valid) last_q <= blk_last;
                end
                S_LOAD: begin
                    round_idx <= '0;
                end
                S_ROUND: begin
                    if (round_idx == LAST_IDX) round_idx <= '0;
                    else                       round_idx <= round_idx + 1'b1;
                end
                S_UPDATE: begin
                    if (blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb/tb_sha_round_sequencer.sv - scoreboard bench for sha_round_sequencer
module tb_sha_round_sequencer;

    logic inclk = 1'b0;
    always #5 inclk = ~inclk;

    logic reset_n   = 1'b0;
    logic start     = 1'b0;
    logic abort     = 1'b0;
    logic blk_valid = 1'b0;
    logic blk_last  = 1'b0;
    logic dig_ready = 1'b0;
    logic dsel      = 1'b0;

    int cyc = 0;
    always @(posedge inclk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic       o0_rdy, o0_init, o0_load, o0_ren, o0_wsel, o0_upd, o0_busy, o0_dv;
    logic [5:0] o0_idx;
    logic [7:0] o0_cnt;
    logic       o1_rdy, o1_init, o1_load, o1_ren, o1_wsel, o1_upd, o1_busy, o1_dv;
    logic [6:0] o1_idx;
    logic [1:0] o1_cnt;

    sha_round_sequencer #(.ROUNDS(64), .IDX_W(6), .MSG_W(16), .BLK_CNT_W(8)) u0 (
        .inclk(inclk), .reset_n(reset_n),
        .start(start & ~dsel), .abort(abort & ~dsel),
        .blk_valid(blk_valid & ~dsel), .blk_last(blk_last),
        .blk_ready(o0_rdy), .init_h(o0_init), .load(o0_load), .round_en(o0_ren),
        .round_idx(o0_idx), .w_sel(o0_wsel), .hash_upd(o0_upd), .blk_cnt(o0_cnt),
        .busy(o0_busy), .dig_valid(o0_dv), .dig_ready(dig_ready & ~dsel)
    );

    sha_round_sequencer #(.ROUNDS(80), .IDX_W(7), .MSG_W(16), .BLK_CNT_W(2)) u1 (
        .inclk(inclk), .reset_n(reset_n),
        .start(start & dsel), .abort(abort & dsel),
        .blk_valid(blk_valid & dsel), .blk_last(blk_last),
        .blk_ready(o1_rdy), .init_h(o1_init), .load(o1_load), .round_en(o1_ren),
        .round_idx(o1_idx), .w_sel(o1_wsel), .hash_upd(o1_upd), .blk_cnt(o1_cnt),
        .busy(o1_busy), .dig_valid(o1_dv), .dig_ready(dig_ready & dsel)
    );

    logic       m_blk_ready, m_init_h, m_load, m_round_en, m_w_sel, m_hash_upd, m_busy, m_dig_valid;
    logic [7:0] m_round_idx;
    logic [7:0] m_blk_cnt;
    assign m_blk_ready = dsel ? o1_rdy  : o0_rdy;
    assign m_init_h    = dsel ? o1_init : o0_init;
    assign m_load      = dsel ? o1_load : o0_load;
    assign m_round_en  = dsel ? o1_ren  : o0_ren;
    assign m_w_sel     = dsel ? o1_wsel : o0_wsel;
    assign m_hash_upd  = dsel ? o1_upd  : o0_upd;
    assign m_busy      = dsel ? o1_busy : o0_busy;
    assign m_dig_valid = dsel ? o1_dv   : o0_dv;
    assign m_round_idx = dsel ? {1'b0, o1_idx} : {2'b00, o0_idx};
    assign m_blk_cnt   = dsel ? {6'b0, o1_cnt} : o0_cnt;

    // Expected strobe events: kind 0 init_h, 1 load, 2 round, 3 hash_upd, 4 dig_valid rise
    typedef struct {
        int cyc;
        int kind;
        int idx;
        int wsel;
        int bcnt;
    } ev_t;
    ev_t exq[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic longint pk(input int c, input int k, input int i, input int w, input int b);
        return longint'({c, k[3:0], i[7:0], w[0], b[7:0]});
    endfunction

    function automatic int rounds_cur();
        return dsel ? 80 : 64;
    endfunction

    function automatic int sat(input int n);
        int mx;
        mx = dsel ? 3 : 255;
        return (n > mx) ? mx : n;
    endfunction

    task automatic push(input int c, input int k, input int i, input int w, input int b);
        ev_t e;
        e.cyc = c; e.kind = k; e.idx = i; e.wsel = w; e.bcnt = b;
        exq.push_back(e);
    endtask

    task automatic flush_from(input int c);
        ev_t keep[$];
        foreach (exq[j]) if (exq[j].cyc < c) keep.push_back(exq[j]);
        exq = keep;
    endtask

    task automatic obs(input int k, input int i, input int w, input int b);
        ev_t e;
        if (exq.size() == 0) begin
            chk($sformatf("unexpected_event_kind%0d", k), pk(cyc, k, i, w, b), 0);
        end else begin
            e = exq.pop_front();
            chk($sformatf("event_kind%0d", e.kind), pk(cyc, k, i, w, b),
                pk(e.cyc, e.kind, e.idx, e.wsel, e.bcnt));
        end
    endtask

    // Monitor: turns every visible strobe into an event and matches it against the scoreboard
    logic prev_dig = 1'b0;
    always @(negedge inclk) begin
        if (!reset_n) begin
            prev_dig <= 1'b0;
        end else begin
            if (m_init_h) obs(0, 0, 0, 0);
            if (m_load)   obs(1, 0, 0, 0);
            if (m_round_en) obs(2, int'(m_round_idx), int'(m_w_sel), 0);
            else chk("idx_wsel_outside_round", longint'({m_round_idx, m_w_sel}), 0);
            if (m_hash_upd) obs(3, 0, 0, int'(m_blk_cnt));
            if (m_dig_valid && !prev_dig) obs(4, 0, 0, int'(m_blk_cnt));
            prev_dig <= m_dig_valid;
        end
    end

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic begin_msg();
        tick();
        start = 1'b1;
        push(cyc + 1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
    endtask

    task automatic send_blk(input bit last, input int dly, input int bidx);
        int t;
        int r;
        int waited;
        r = rounds_cur();
        waited = 0;
        repeat (dly) tick();
        blk_valid = 1'b1;
        blk_last  = last;
        @(negedge inclk);
        while (!m_blk_ready && waited < 400) begin
            waited++;
            @(negedge inclk);
        end
        if (!m_blk_ready) begin
            chk("blk_ready_timeout", 1, 0);
            blk_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        push(t, 1, 0, 0, 0);
        for (int k = 0; k < r; k++) push(t + 1 + k, 2, k, (k < 16) ? 1 : 0, 0);
        push(t + r + 1, 3, 0, 0, sat(bidx));
        if (last) push(t + r + 2, 4, 0, 0, sat(bidx + 1));
        tick();
        blk_valid = 1'b0;
        blk_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_msg(input int hold, input int nblk);
        int waited;
        waited = 0;
        @(negedge inclk);
        while (!m_dig_valid && waited < 400) begin
            waited++;
            @(negedge inclk);
        end
        if (!m_dig_valid) begin
            chk("dig_valid_timeout", 1, 0);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            start = (i == hold / 2);
            @(negedge inclk);
            chk("dig_valid_held", longint'({m_dig_valid, m_busy}), 3);
        end
        tick();
        start     = 1'b0;
        dig_ready = 1'b1;
        tick();
        dig_ready = 1'b0;
        @(negedge inclk);
        chk("idle_after_dig_ready", longint'({m_dig_valid, m_busy}), 0);
        chk("blk_cnt_final", longint'(m_blk_cnt), sat(nblk));
    endtask

    task automatic do_msg(input int nblk, input int mindly, input int maxdly, input int hold);
        begin_msg();
        for (int b = 0; b < nblk; b++)
            send_blk(b == nblk - 1, int'($urandom_range(mindly, maxdly)), b);
        finish_msg(hold, nblk);
    endtask

    task automatic wait_idx(input int target);
        int waited;
        waited = 0;
        @(negedge inclk);
        while (!(m_round_en && int'(m_round_idx) == target) && waited < 400) begin
            waited++;
            @(negedge inclk);
        end
        if (!(m_round_en && int'(m_round_idx) == target)) chk("round_idx_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge inclk);
        chk("reset_outputs", longint'({m_busy, m_blk_ready, m_init_h, m_load, m_round_en,
            m_hash_upd, m_dig_valid, m_w_sel, m_round_idx, m_blk_cnt}), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single block, then a 3-block message with delayed sources
        do_msg(1, 0, 0, 3);
        do_msg(3, 5, 5, 2);

        // Random message shapes
        repeat (3) do_msg(int'($urandom_range(1, 3)), 0, 4, int'($urandom_range(0, 4)));

        // Long digest back-pressure with a start pulse that must be ignored
        do_msg(1, 0, 2, 10);

        // Abort mid-rounds of the second block
        begin_msg();
        send_blk(1'b0, 0, 0);
        send_blk(1'b0, 1, 1);
        wait_idx(30);
        abort = 1'b1;
        flush_from(cyc + 1);
        tick();
        abort = 1'b0;
        @(negedge inclk);
        chk("after_abort", longint'({m_busy, m_round_idx, m_blk_cnt}), 0);
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        @(negedge inclk);
        chk("abort_start_stays_idle", longint'({m_busy, m_init_h}), 0);

        // Asynchronous reset mid-rounds, then a clean restart
        begin_msg();
        send_blk(1'b1, 0, 0);
        wait_idx(40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", longint'({m_busy, m_blk_ready, m_init_h, m_load, m_round_en,
            m_hash_upd, m_dig_valid, m_w_sel, m_round_idx, m_blk_cnt}), 0);
        exq.delete();
        tick();
        reset_n = 1'b1;
        do_msg(1, 0, 2, 1);

        // 80-round instance with a 2-bit saturating block counter
        tick();
        dsel = 1'b1;
        do_msg(1, 0, 0, 2);
        do_msg(5, 0, 2, 1);

        tick();
        chk("scoreboard_empty", longint'(exq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
